universal_shift_reg_n: RTL and testbench
========================================

// Module: universal_shift_reg_n
// PURPOSE
//  Parametrised universal shift register: N-bit successor of the 4-bit
//  universal shifter, with rotate and arithmetic modes and an autonomous burst mode.
//  Burst mode loads a word, then shifts it right a programmed number of times
//  under its own control, with BUSY/DONE status.
//  Used as the serialiser/shift core for the emulated shift-register families.
// PARAMETERS
//  WIDTH  8  register width in bits, >= 2
//  CNT_W  4  burst count width in bits; max burst length = 2**CNT_W-1
// PORTS
//  CLK    in   1      clock, rising-edge
//  CLR    in   1      reset, asynchronous, active-low
//  MODE   in   3      operation select (see BEHAVIOUR); ignored while BUSY=1
//  D      in   WIDTH  parallel load data
//  SR     in   1      serial in, shift-right (enters Q[WIDTH-1])
//  SL     in   1      serial in, shift-left (enters Q[0])
//  CNT    in   CNT_W  burst shift count, sampled on burst start
//  ABORT  in   1      synchronous burst cancel
//  Q      out  WIDTH  register contents; Q[WIDTH-1] = "QA" end
//  SOUT_R out  1      = Q[0], combinational
//  SOUT_L out  1      = Q[WIDTH-1], combinational
//  BUSY   out  1      burst shifting in progress, registered
//  DONE   out  1      one-cycle pulse at burst completion, registered
// BEHAVIOUR
//  - CLR=0: Q=0, BUSY=0, DONE=0, internal count=0 immediately, regardless of CLK.
//  - All other updates on the rising CLK edge. DONE defaults to 0 on every edge.
//  - Idle (BUSY=0) MODE decode:
//      000 hold | 001 SHR Q<={SR,Q[W-1:1]} | 010 SHL Q<={Q[W-2:0],SL}
//      011 load Q<=D | 100 ROR Q<={Q[0],Q[W-1:1]} | 101 ROL Q<={Q[W-2:0],Q[W-1]}
//      110 ASR Q<={Q[W-1],Q[W-1:1]} | 111 burst start
//  - FSM states: IDLE, SHIFT. BUSY=1 exactly in SHIFT.
//  - Burst start (IDLE, MODE=111): Q<=D, REM<=CNT.
//      CNT=0: stay IDLE, DONE<=1 (pulse on the following cycle).
//      CNT>0: go to SHIFT.
//  - SHIFT, each edge: Q<=SHR with current SR; REM<=REM-1.
//      On the edge where REM==1: go to IDLE, DONE<=1.
//  - Latency: DONE high during the cycle after edge CNT+1 counted from the start edge.
//  - MODE, D and CNT are ignored in SHIFT. CNT > WIDTH is legal; shifting simply continues.
//  - ABORT=1 has priority over everything except CLR:
//      Q holds, go/stay IDLE, REM<=0, DONE<=0.
//      ABORT during IDLE also blocks that cycle's MODE operation.
//  - A new burst may start on the edge immediately after DONE is asserted.
// STRUCTURE
//  - Shared package usr_pkg: localparams for the MODE codes (MODE_HOLD..MODE_BURST)
//    and the FSM state encoding.
//  - One sub-module, usr_burst_ctl: FSM + REM down-counter.
//      Inputs: start, ABORT, CNT.
//      Outputs: BUSY, DONE, shift_en.
//  - Top level: datapath mux selecting Q's next value.
// TESTING (WIDTH=8, CNT_W=4)
//  1. Pulse CLR low mid-burst, with no CLK edge -> Q=0x00, BUSY=0, DONE=0 immediately.
//  2. Load D=0xA5 -> Q=0xA5. SHR with SR=1 -> 0xD2. SHL with SL=0 -> 0xA4.
//  3. Q=0x81: ROR -> 0xC0; ROL from 0x81 -> 0x03. Q=0x80: ASR -> 0xC0.
//  4. Burst with D=0xF0, CNT=4, SR=0 -> BUSY for 4 cycles, final Q=0x0F,
//     then a single DONE cycle; toggling MODE during BUSY has no effect.
//  5. Burst with CNT=0, D=0x3C -> Q=0x3C, BUSY never set, DONE high for 1 cycle.
//  6. CNT=5 burst, ABORT on the 2nd shift edge -> Q holds the value after 1 shift,
//     BUSY=0, no DONE; a new burst issued the next cycle is accepted.

Source files
------------

// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usr_pkg
//  Description : Shared definitions for the universal shift register:
//                MODE operation codes and burst FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

   // MODE operation codes (honoured only while the burst FSM is idle)
   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_SHR   = 3'b001;
   localparam logic [2:0] MODE_SHL   = 3'b010;
   localparam logic [2:0] MODE_LOAD  = 3'b011;
   localparam logic [2:0] MODE_ROR   = 3'b100;
   localparam logic [2:0] MODE_ROL   = 3'b101;
   localparam logic [2:0] MODE_ASR   = 3'b110;
   localparam logic [2:0] MODE_BURST = 3'b111;

   // Burst FSM state encoding
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   typedef enum logic [0:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT
   } burst_state_t;

endpackage : usr_pkg
`default_nettype wire

// File: rtl/universal_shift_reg_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : universal_shift_reg_n_if
//  Description : Control/data bundle of the universal shift register.
//                master : drives MODE, D, SR, SL, CNT, ABORT
//                slave  : drives Q, SOUT_R, SOUT_L, BUSY, DONE
//  Revision    : 1.0 - initial release
// ============================================================================
interface universal_shift_reg_n_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic [2:0]       MODE;
   logic [WIDTH-1:0] D;
   logic             SR;
   logic             SL;
   logic [CNT_W-1:0] CNT;
   logic             ABORT;
   logic [WIDTH-1:0] Q;
   logic             SOUT_R;
   logic             SOUT_L;
   logic             BUSY;
   logic             DONE;

   modport master (
      output MODE, D, SR, SL, CNT, ABORT,
      input  Q, SOUT_R, SOUT_L, BUSY, DONE
   );

   modport slave (
      input  MODE, D, SR, SL, CNT, ABORT,
      output Q, SOUT_R, SOUT_L, BUSY, DONE
   );
endinterface : universal_shift_reg_n_if
`default_nettype wire

// File: rtl/usr_burst_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : usr_burst_ctl
//  Description : Burst controller: IDLE/SHIFT FSM plus remaining-shift
//                down-counter.
//  Ports       : CLK      in  clock, rising edge
//                CLR      in  asynchronous active-low reset
//                i_start  in  MODE requests a burst (acted on only in IDLE)
//                i_abort  in  synchronous burst cancel, highest priority
//                i_cnt    in  burst length, sampled on burst start
//                o_busy   out high exactly while in SHIFT (registered)
//                o_done   out one-cycle completion pulse (registered)
//                o_shift_en out datapath must shift right on this edge
//  Revision    : 1.0 - initial release
// ============================================================================
module usr_burst_ctl
   import usr_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  wire logic             CLK,
   input  wire logic             CLR,
   input  wire logic             i_start,
   input  wire logic             i_abort,
   input  wire logic [CNT_W-1:0] i_cnt,
   output      logic             o_busy,
   output      logic             o_done,
   output      logic             o_shift_en
);

   burst_state_t     r_state;
   burst_state_t     w_state_nxt;
   logic [CNT_W-1:0] r_rem;
   logic [CNT_W-1:0] w_rem_nxt;
   logic             r_done;
   logic             w_done_nxt;

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_state <= IDLE;
         r_rem   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      w_done_nxt  = 1'b0;
      o_shift_en  = 1'b0;
      if (i_abort) begin
         w_state_nxt = IDLE;
         w_rem_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  w_rem_nxt = i_cnt;
                  // A zero-length burst completes immediately without shifting
                  if (i_cnt == '0) begin
                     w_done_nxt = 1'b1;
                  end else begin
                     w_state_nxt = SHIFT;
                  end
               end
            end
            SHIFT: begin
               o_shift_en = 1'b1;
               w_rem_nxt  = r_rem - CNT_W'(1);
               if (r_rem == CNT_W'(1)) begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   assign o_busy = (r_state == SHIFT);
   assign o_done = r_done;

endmodule : usr_burst_ctl
`default_nettype wire

// File: rtl/universal_shift_reg_n.sv
`default_nettype none
// ============================================================================
//  Module      : universal_shift_reg_n
//  Description : Parametrised universal shift register with shift, rotate,
//                arithmetic-shift, parallel load and autonomous burst mode.
//  Ports       : CLK  in  clock, rising edge
//                CLR  in  asynchronous active-low reset
//                bus  slave modport: MODE, D, SR, SL, CNT, ABORT in;
//                     Q, SOUT_R, SOUT_L, BUSY, DONE out
//  Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_reg_n
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input wire logic                CLK,
   input wire logic                CLR,
   universal_shift_reg_n_if.slave  bus
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_busy;
   logic             w_done;
   logic             w_shift_en;
   logic             w_start;

   assign w_start = (bus.MODE == MODE_BURST);

   usr_burst_ctl #(
      .CNT_W (CNT_W)
   ) u_burst_ctl (
      .CLK        (CLK),
      .CLR        (CLR),
      .i_start    (w_start),
      .i_abort    (bus.ABORT),
      .i_cnt      (bus.CNT),
      .o_busy     (w_busy),
      .o_done     (w_done),
      .o_shift_en (w_shift_en)
   );

   // Next-value mux. ABORT freezes Q; while busy, MODE/D are ignored and
   // only the burst shift-right can move the register.
   always_comb begin
      w_q_nxt = r_q;
      if (bus.ABORT) begin
         w_q_nxt = r_q;
      end else if (w_busy) begin
         if (w_shift_en) begin
            w_q_nxt = {bus.SR, r_q[WIDTH-1:1]};
         end
      end else begin
         case (bus.MODE)
            MODE_SHR:   w_q_nxt = {bus.SR, r_q[WIDTH-1:1]};
            MODE_SHL:   w_q_nxt = {r_q[WIDTH-2:0], bus.SL};
            MODE_LOAD:  w_q_nxt = bus.D;
            MODE_ROR:   w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
            MODE_ROL:   w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            MODE_ASR:   w_q_nxt = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            MODE_BURST: w_q_nxt = bus.D;
            default:    w_q_nxt = r_q;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_q <= '0;
      end else begin
         r_q <= w_q_nxt;
      end
   end

   assign bus.Q      = r_q;
   assign bus.SOUT_R = r_q[0];
   assign bus.SOUT_L = r_q[WIDTH-1];
   assign bus.BUSY   = w_busy;
   assign bus.DONE   = w_done;

endmodule : universal_shift_reg_n
`default_nettype wire

// File: tb/tb_universal_shift_reg_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_universal_shift_reg_n
//  Description : Directed self-checking bench for universal_shift_reg_n
//                (WIDTH=8, CNT_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_shift_reg_n;

   logic CLK;
   logic CLR;
   int   n_checks;
   int   n_errors;

   universal_shift_reg_n_if #(.WIDTH(8), .CNT_W(4)) bus ();

   universal_shift_reg_n #(
      .WIDTH (8),
      .CNT_W (4)
   ) dut (
      .CLK (CLK),
      .CLR (CLR),
      .bus (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [2:0] mode, input logic [7:0] d,
                        input logic sr, input logic sl, input logic [3:0] cnt);
      bus.MODE = mode;
      bus.D    = d;
      bus.SR   = sr;
      bus.SL   = sl;
      bus.CNT  = cnt;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      CLR       = 1'b0;
      bus.ABORT = 1'b0;
      drive(3'b000, 8'h00, 1'b0, 1'b0, 4'd0);
      #3;
      chk("rst_q",    bus.Q,    8'h00);
      chk("rst_busy", bus.BUSY, 1'b0);
      chk("rst_done", bus.DONE, 1'b0);
      #4 CLR = 1'b1;

      // Load / shift right / shift left
      drive(3'b011, 8'hA5, 1'b0, 1'b0, 4'd0); step();
      chk("load",  bus.Q, 8'hA5);
      drive(3'b001, 8'h00, 1'b1, 1'b0, 4'd0); step();
      chk("shr",   bus.Q, 8'hD2);
      drive(3'b010, 8'h00, 1'b0, 1'b0, 4'd0); step();
      chk("shl",   bus.Q, 8'hA4);
      chk("sout_r", bus.SOUT_R, 1'b0);
      chk("sout_l", bus.SOUT_L, 1'b1);

      // Rotate and arithmetic shift
      drive(3'b011, 8'h81, 1'b0, 1'b0, 4'd0); step();
      drive(3'b100, 8'h00, 1'b0, 1'b0, 4'd0); step();
      chk("ror",   bus.Q, 8'hC0);
      drive(3'b011, 8'h81, 1'b0, 1'b0, 4'd0); step();
      drive(3'b101, 8'h00, 1'b0, 1'b0, 4'd0); step();
      chk("rol",   bus.Q, 8'h03);
      drive(3'b011, 8'h80, 1'b0, 1'b0, 4'd0); step();
      drive(3'b110, 8'h00, 1'b1, 1'b1, 4'd0); step();
      chk("asr",   bus.Q, 8'hC0);
      drive(3'b000, 8'hFF, 1'b1, 1'b1, 4'd0); step();
      chk("hold",  bus.Q, 8'hC0);

      // ABORT in idle blocks the MODE operation
      drive(3'b011, 8'h55, 1'b0, 1'b0, 4'd0);
      bus.ABORT = 1'b1; step();
      chk("abort_idle", bus.Q, 8'hC0);
      bus.ABORT = 1'b0;

      // Burst CNT=4 from 0xF0; MODE/D/CNT changes while busy are ignored
      drive(3'b111, 8'hF0, 1'b0, 1'b0, 4'd4); step();
      chk("b4_start_q",    bus.Q,    8'hF0);
      chk("b4_start_busy", bus.BUSY, 1'b1);
      drive(3'b011, 8'hFF, 1'b0, 1'b1, 4'd9); step();
      chk("b4_s1", bus.Q, 8'h78);
      chk("b4_s1_busy", bus.BUSY, 1'b1);
      bus.MODE = 3'b010; step();
      chk("b4_s2", bus.Q, 8'h3C);
      bus.MODE = 3'b101; step();
      chk("b4_s3", bus.Q, 8'h1E);
      chk("b4_s3_busy", bus.BUSY, 1'b1);
      chk("b4_s3_done", bus.DONE, 1'b0);
      bus.MODE = 3'b111; step();
      chk("b4_end_q",    bus.Q,    8'h0F);
      chk("b4_end_busy", bus.BUSY, 1'b0);
      chk("b4_end_done", bus.DONE, 1'b1);
      bus.MODE = 3'b000; step();
      chk("b4_done_pulse", bus.DONE, 1'b0);
      chk("b4_after_q",    bus.Q,    8'h0F);

      // Zero-length burst
      drive(3'b111, 8'h3C, 1'b0, 1'b0, 4'd0); step();
      chk("b0_q",    bus.Q,    8'h3C);
      chk("b0_busy", bus.BUSY, 1'b0);
      chk("b0_done", bus.DONE, 1'b1);
      bus.MODE = 3'b000; step();
      chk("b0_done_pulse", bus.DONE, 1'b0);
      chk("b0_hold", bus.Q, 8'h3C);

      // CNT=5 burst aborted on the 2nd shift edge
      drive(3'b111, 8'hF0, 1'b1, 1'b0, 4'd5); step();
      chk("ab_start", bus.Q, 8'hF0);
      step();
      chk("ab_s1", bus.Q, 8'hF8);
      bus.ABORT = 1'b1; step();
      chk("ab_q",    bus.Q,    8'hF8);
      chk("ab_busy", bus.BUSY, 1'b0);
      chk("ab_done", bus.DONE, 1'b0);
      bus.ABORT = 1'b0;
      drive(3'b111, 8'h81, 1'b0, 1'b0, 4'd1); step();
      chk("ab_new_q",    bus.Q,    8'h81);
      chk("ab_new_busy", bus.BUSY, 1'b1);
      bus.MODE = 3'b000; step();
      chk("b1_q",    bus.Q,    8'h40);
      chk("b1_done", bus.DONE, 1'b1);

      // New burst on the edge right after DONE
      drive(3'b111, 8'h99, 1'b0, 1'b0, 4'd0); step();
      chk("b2b_q",    bus.Q,    8'h99);
      chk("b2b_done", bus.DONE, 1'b1);

      // Long burst (CNT > WIDTH), asynchronous reset between edges
      drive(3'b111, 8'hFF, 1'b1, 1'b0, 4'd15); step();
      bus.MODE = 3'b000; step();
      chk("long_s1",   bus.Q,    8'hFF);
      chk("long_busy", bus.BUSY, 1'b1);
      #2 CLR = 1'b0;
      #1;
      chk("clr_q",    bus.Q,    8'h00);
      chk("clr_busy", bus.BUSY, 1'b0);
      chk("clr_done", bus.DONE, 1'b0);
      #1 CLR = 1'b1;
      step();
      chk("clr_after_busy", bus.BUSY, 1'b0);
      chk("clr_after_q",    bus.Q,    8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_universal_shift_reg_n
`default_nettype wire
